// File: rtl/blake2_host.sv
// blake2_host: initiator for the BLAKE2s byte-serial pin protocol.
// Sends CONF (10 bytes), START, then padded 64-byte key/message blocks.
// Collects nn digest bytes from the target.
// Optional build macro: BLAKE2_HOST_TIMEOUT_EN adds a hash-wait watchdog.
// Handshakes: a pin transfer happens in a cycle with valid_o & ready_v_i.
// valid_o/cmd_o/data_o hold while ready_v_i is low.
// A stream byte is taken in a cycle with msg_v_i & msg_ready_o.
module blake2_host #(
   parameter int TIMEOUT_W = 16
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start_i,
   input  logic [5:0]  kk_i,
   input  logic [5:0]  nn_i,
   input  logic [63:0] ll_i,
   input  logic        msg_v_i,
   input  logic [7:0]  msg_i,
   output logic        msg_ready_o,
   output logic        valid_o,
   output logic [1:0]  cmd_o,
   output logic [7:0]  data_o,
   output logic [1:0]  loopback_mode_o,
   input  logic        ready_v_i,
   input  logic        hash_v_i,
   input  logic [7:0]  hash_i,
   output logic        digest_v_o,
   output logic [7:0]  digest_o,
   output logic [4:0]  digest_idx_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [2:0]  state_dbg_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CONF, S_START, S_KEY, S_MSG, S_PAD, S_WAIT_HASH, S_HASH
   } state_t;

   state_t      state;
   logic [5:0]  kk_q;
   logic [5:0]  nn_q;
   logic [63:0] ll_q;
   logic [63:0] rem;
   logic [5:0]  idx;
   logic        last_blk;
   logic [4:0]  dig_cnt;
   logic        can_load;
   logic        msg_take;
   logic [1:0]  blk_cmd;
   logic [2:0]  conf_sel;
   logic [7:0]  conf_byte;

   assign can_load        = !valid_o || ready_v_i;
   assign msg_ready_o     = ((state == S_KEY) || (state == S_MSG)) && can_load;
   assign msg_take        = msg_v_i && msg_ready_o;
   assign blk_cmd         = last_blk ? 2'd3 : 2'd2;
   assign busy_o          = (state != S_IDLE);
   assign loopback_mode_o = 2'b00;
   assign state_dbg_o     = state;

   // Select CONF byte idx: 1 is nn, 2..9 are ll little-endian
   always_comb begin
      conf_sel  = idx[2:0] - 3'd2;
      conf_byte = ll_q[{conf_sel, 3'b000} +: 8];
      if (idx == 6'd1) conf_byte = {2'b00, nn_q};
   end

`ifdef BLAKE2_HOST_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo;
`endif

   // Main FSM: each state loads the next pin byte when the output register frees up
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= S_IDLE;
         kk_q         <= '0;
         nn_q         <= '0;
         ll_q         <= '0;
         rem          <= '0;
         idx          <= '0;
         last_blk     <= 1'b0;
         dig_cnt      <= '0;
         valid_o      <= 1'b0;
         cmd_o        <= 2'd0;
         data_o       <= 8'd0;
         digest_v_o   <= 1'b0;
         digest_o     <= 8'd0;
         digest_idx_o <= 5'd0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
`ifdef BLAKE2_HOST_TIMEOUT_EN
         tmo          <= '0;
`endif
      end else begin
         error_o    <= 1'b0;
         done_o     <= 1'b0;
         digest_v_o <= 1'b0;
         if (ready_v_i) valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  if (kk_i > 6'd32 || nn_i == 6'd0 || nn_i > 6'd32) begin
                     error_o <= 1'b1;
                  end else begin
                     kk_q    <= kk_i;
                     nn_q    <= nn_i;
                     ll_q    <= ll_i;
                     valid_o <= 1'b1;
                     cmd_o   <= 2'd0;
                     data_o  <= {2'b00, kk_i};
                     idx     <= 6'd1;
                     state   <= S_CONF;
                  end
               end
            end
            S_CONF: begin
               if (can_load) begin
                  valid_o <= 1'b1;
                  cmd_o   <= 2'd0;
                  data_o  <= conf_byte;
                  if (idx == 6'd9) begin
                     idx   <= 6'd0;
                     state <= S_START;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            S_START: begin
               if (can_load) begin
                  valid_o <= 1'b1;
                  cmd_o   <= 2'd1;
                  data_o  <= 8'h00;
                  rem     <= ll_q;
                  idx     <= 6'd0;
                  if (kk_q != 6'd0) begin
                     last_blk <= (ll_q == 64'd0);
                     state    <= S_KEY;
                  end else if (ll_q != 64'd0) begin
                     last_blk <= (ll_q <= 64'd64);
                     state    <= S_MSG;
                  end else begin
                     last_blk <= 1'b1;
                     state    <= S_PAD;
                  end
               end
            end
            S_KEY: begin
               if (msg_take) begin
                  valid_o <= 1'b1;
                  cmd_o   <= blk_cmd;
                  data_o  <= msg_i;
                  idx     <= idx + 6'd1;
                  if (idx == kk_q - 6'd1) state <= S_PAD;
               end
            end
            S_MSG: begin
               if (msg_take) begin
                  valid_o <= 1'b1;
                  cmd_o   <= blk_cmd;
                  data_o  <= msg_i;
                  rem     <= rem - 64'd1;
                  idx     <= idx + 6'd1;
                  if (idx == 6'd63) begin
                     if (rem == 64'd1) state <= S_WAIT_HASH;
                     else last_blk <= (rem <= 64'd65);
                  end else if (rem == 64'd1) begin
                     state <= S_PAD;
                  end
               end
            end
            S_PAD: begin
               if (can_load) begin
                  valid_o <= 1'b1;
                  cmd_o   <= blk_cmd;
                  data_o  <= 8'h00;
                  idx     <= idx + 6'd1;
                  if (idx == 6'd63) begin
                     if (last_blk) begin
                        state <= S_WAIT_HASH;
                     end else begin
                        last_blk <= (rem <= 64'd64);
                        state    <= S_MSG;
                     end
                  end
               end
            end
            S_WAIT_HASH: begin
               if (hash_v_i) begin
                  digest_v_o   <= 1'b1;
                  digest_o     <= hash_i;
                  digest_idx_o <= 5'd0;
                  dig_cnt      <= 5'd1;
                  if (nn_q == 6'd1) begin
                     done_o <= 1'b1;
                     state  <= S_IDLE;
                  end else begin
                     state <= S_HASH;
                  end
               end
            end
            S_HASH: begin
               if (hash_v_i) begin
                  digest_v_o   <= 1'b1;
                  digest_o     <= hash_i;
                  digest_idx_o <= dig_cnt;
                  dig_cnt      <= dig_cnt + 5'd1;
                  if ({1'b0, dig_cnt} == nn_q - 6'd1) begin
                     done_o <= 1'b1;
                     state  <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
`ifdef BLAKE2_HOST_TIMEOUT_EN
         if (state == S_WAIT_HASH || state == S_HASH) begin
            if (hash_v_i) begin
               tmo <= '0;
            end else if (&tmo) begin
               error_o <= 1'b1;
               state   <= S_IDLE;
               tmo     <= '0;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end else begin
            tmo <= '0;
         end
`endif
      end
   end

endmodule
